control_unit_mc: RTL and testbench

- Parametrised multicycle control FSM for the RISC-V core; successor of the current single-latency control unit.
- Decodes IR, sequences datapath enables and mux selects per instruction class, and stalls on a configurable memory latency.
- Adds full branch set (beq/bne/blt/bge), jal/jalr, immediate shifts, an illegal-opcode trap through EPC, and an ebreak halt.
- Sits between IR/ALU flags and the datapath of the CPU top level.

---
 rtl/ctrl_pkg.sv | 125 ++++++++++++
 rtl/control_unit_mc.sv | 258 +++++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : shared types, opcodes and select encodings for control_unit_mc
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

   typedef enum logic [4:0] {
      S_RESET  = 5'd0,
      S_FETCH  = 5'd1,
      S_DECODE = 5'd2,
      S_EXEC_R = 5'd3,
      S_EXEC_I = 5'd4,
      S_SHIFT  = 5'd5,
      S_ADDR   = 5'd6,
      S_MEM_RD = 5'd7,
      S_MEM_WR = 5'd8,
      S_WB_ALU = 5'd9,
      S_WB_MEM = 5'd10,
      S_BRANCH = 5'd11,
      S_JAL    = 5'd12,
      S_JALR   = 5'd13,
      S_LUI    = 5'd14,
      S_TRAP   = 5'd15,
      S_HALT   = 5'd16
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_SUB   = 3'd1,
      ALU_AND   = 3'd2,
      ALU_OR    = 3'd3,
      ALU_SLT   = 3'd4,
      ALU_PASSB = 3'd5
   } alu_op_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_REG   = 2'd1;
   localparam logic [1:0] SRC_A_ZERO  = 2'd2;
   localparam logic [1:0] SRC_A_PCOLD = 2'd3;

   localparam logic [1:0] SRC_B_REG  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_TRAP   = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_IMM    = 2'd2;
   localparam logic [1:0] WB_PC     = 2'd3;

   localparam logic [1:0] SH_NONE = 2'd0;
   localparam logic [1:0] SH_SLL  = 2'd1;
   localparam logic [1:0] SH_SRL  = 2'd2;
   localparam logic [1:0] SH_SRA  = 2'd3;

   function automatic logic branch_f3_ok(input logic [2:0] funct3);
      return (funct3 == F3_BEQ) || (funct3 == F3_BNE) ||
             (funct3 == F3_BLT) || (funct3 == F3_BGE);
   endfunction

   function automatic logic branch_taken(input logic [2:0] funct3,
                                         input logic zero, input logic lt);
      return ((funct3 == F3_BEQ) &&  zero) || ((funct3 == F3_BNE) && !zero) ||
             ((funct3 == F3_BLT) &&  lt)   || ((funct3 == F3_BGE) && !lt);
   endfunction

   // Only ADD/SUB/AND/OR/SLT are implemented in R-type; anything else traps.
   function automatic logic r_funct_ok(input logic [6:0] funct7, input logic [2:0] funct3);
      return ((funct7 == 7'b0000000) &&
              ((funct3 == 3'b000) || (funct3 == 3'b111) ||
               (funct3 == 3'b110) || (funct3 == 3'b010))) ||
             ((funct7 == 7'b0100000) && (funct3 == 3'b000));
   endfunction

   function automatic alu_op_t r_alu_op(input logic [6:0] funct7, input logic [2:0] funct3);
      alu_op_t op;
      case (funct3)
         3'b000:  op = funct7[5] ? ALU_SUB : ALU_ADD;
         3'b111:  op = ALU_AND;
         3'b110:  op = ALU_OR;
         3'b010:  op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   function automatic logic i_funct_ok(input logic [2:0] funct3);
      return (funct3 == 3'b000) || (funct3 == 3'b010) ||
             (funct3 == 3'b110) || (funct3 == 3'b111);
   endfunction

   function automatic alu_op_t i_alu_op(input logic [2:0] funct3);
      alu_op_t op;
      case (funct3)
         3'b010:  op = ALU_SLT;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/control_unit_mc.sv
// ============================================================================
// control_unit_mc : multicycle RISC-V control FSM with memory-latency stalls
// Rev 1.0         : initial release
// ============================================================================
`default_nettype none

module control_unit_mc
   import ctrl_pkg::*;
#(
   parameter int MEM_LAT = 1,   // 1..15
   parameter int XLEN    = 64,
   parameter int TRAP_EN = 1,
   localparam int SHW    = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   input  logic            alu_zero,
   input  logic            alu_lt,
   output logic            pc_write,
   output logic            ir_load,
   output logic            mem_read,
   output logic            mem_write,
   output logic            rega_load,
   output logic            regb_load,
   output logic            aluout_load,
   output logic            mdr_load,
   output logic            reg_write,
   output logic            epc_load,
   output logic [2:0]      alu_op,
   output logic [1:0]      alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      pc_src,
   output logic [1:0]      wb_sel,
   output logic [1:0]      shift_op,
   output logic [SHW-1:0]  shift_amt,
   output logic            illegal,
   output logic            halted,
   output logic [4:0]      state_dbg
);

   localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

   state_t      state;
   state_t      next_state;
   state_t      illegal_dest;
   logic [3:0]  wait_cnt;
   logic        wait_last;
   logic        in_wait_state;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7       = instr[31:25];
   assign unused_instr = ^{instr[19:7], instr[25:20]};

   assign illegal_dest  = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
   assign wait_last     = (wait_cnt == LAST_CNT);
   assign in_wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
   assign state_dbg     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_RESET;
         wait_cnt <= 4'd0;
      end else begin
         state <= next_state;
         if (in_wait_state && !wait_last)
            wait_cnt <= wait_cnt + 4'd1;
         else
            wait_cnt <= 4'd0;
      end
   end

   always_comb begin
      next_state  = state;
      pc_write    = 1'b0;
      ir_load     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      rega_load   = 1'b0;
      regb_load   = 1'b0;
      aluout_load = 1'b0;
      mdr_load    = 1'b0;
      reg_write   = 1'b0;
      epc_load    = 1'b0;
      alu_op      = ALU_ADD;
      alu_src_a   = SRC_A_PC;
      alu_src_b   = SRC_B_REG;
      pc_src      = PC_SRC_ALU;
      wb_sel      = WB_ALUOUT;
      shift_op    = SH_NONE;
      shift_amt   = '0;
      illegal     = 1'b0;
      halted      = 1'b0;

      unique case (state)
         S_RESET: next_state = S_FETCH;

         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_a = SRC_A_PC;
            alu_src_b = SRC_B_FOUR;
            alu_op    = ALU_ADD;
            if (wait_last) begin
               ir_load    = 1'b1;
               pc_write   = 1'b1;
               pc_src     = PC_SRC_ALU;
               next_state = S_DECODE;
            end
         end

         // Branch/jal target is precomputed into ALUOut from the old PC.
         S_DECODE: begin
            rega_load   = 1'b1;
            regb_load   = 1'b1;
            aluout_load = 1'b1;
            alu_src_a   = SRC_A_PCOLD;
            alu_src_b   = SRC_B_IMM;
            alu_op      = ALU_ADD;
            case (opcode)
               OP_R:      next_state = r_funct_ok(funct7, funct3) ? S_EXEC_R : illegal_dest;
               OP_IMM: begin
                  if ((funct3 == 3'b001) || (funct3 == 3'b101))
                     next_state = S_SHIFT;
                  else
                     next_state = i_funct_ok(funct3) ? S_EXEC_I : illegal_dest;
               end
               OP_LOAD,
               OP_STORE:  next_state = S_ADDR;
               OP_BRANCH: next_state = branch_f3_ok(funct3) ? S_BRANCH : illegal_dest;
               OP_JAL:    next_state = S_JAL;
               OP_JALR:   next_state = S_JALR;
               OP_LUI:    next_state = S_LUI;
               OP_SYSTEM: next_state = S_HALT;
               default:   next_state = illegal_dest;
            endcase
         end

         S_EXEC_R: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_REG;
            alu_op      = r_alu_op(funct7, funct3);
            aluout_load = 1'b1;
            next_state  = S_WB_ALU;
         end

         S_EXEC_I: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_IMM;
            alu_op      = i_alu_op(funct3);
            aluout_load = 1'b1;
            next_state  = S_WB_ALU;
         end

         S_SHIFT: begin
            if (funct3 == 3'b001)
               shift_op = SH_SLL;
            else
               shift_op = instr[30] ? SH_SRA : SH_SRL;
            shift_amt   = SHW'(instr[25:20]);
            aluout_load = 1'b1;
            next_state  = S_WB_ALU;
         end

         S_ADDR: begin
            alu_src_a   = SRC_A_REG;
            alu_src_b   = SRC_B_IMM;
            alu_op      = ALU_ADD;
            aluout_load = 1'b1;
            next_state  = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end

         S_MEM_RD: begin
            mem_read = 1'b1;
            if (wait_last) begin
               mdr_load   = 1'b1;
               next_state = S_WB_MEM;
            end
         end

         S_MEM_WR: begin
            mem_write = 1'b1;
            if (wait_last)
               next_state = S_FETCH;
         end

         S_WB_ALU: begin
            reg_write  = 1'b1;
            wb_sel     = WB_ALUOUT;
            next_state = S_FETCH;
         end

         S_WB_MEM: begin
            reg_write  = 1'b1;
            wb_sel     = WB_MDR;
            next_state = S_FETCH;
         end

         S_BRANCH: begin
            alu_src_a  = SRC_A_REG;
            alu_src_b  = SRC_B_REG;
            alu_op     = ALU_SUB;
            pc_src     = PC_SRC_ALUOUT;
            pc_write   = branch_taken(funct3, alu_zero, alu_lt);
            next_state = S_FETCH;
         end

         S_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_ALUOUT;
            reg_write  = 1'b1;
            wb_sel     = WB_PC;
            next_state = S_FETCH;
         end

         // The register file latches the link value from the PC before it updates.
         S_JALR: begin
            alu_src_a  = SRC_A_REG;
            alu_src_b  = SRC_B_IMM;
            alu_op     = ALU_ADD;
            pc_src     = PC_SRC_ALU;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            wb_sel     = WB_PC;
            next_state = S_FETCH;
         end

         S_LUI: begin
            reg_write  = 1'b1;
            wb_sel     = WB_IMM;
            next_state = S_FETCH;
         end

         S_TRAP: begin
            epc_load   = 1'b1;
            pc_src     = PC_SRC_TRAP;
            pc_write   = 1'b1;
            illegal    = 1'b1;
            next_state = S_FETCH;
         end

         S_HALT: begin
            halted     = 1'b1;
            next_state = S_HALT;
         end

         default: next_state = S_RESET;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_control_unit_mc.sv
// ============================================================================
// tb_control_unit_mc : directed self-checking bench for control_unit_mc
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module tb_control_unit_mc;
   import ctrl_pkg::*;

   localparam logic [11:0] E_PCW = 12'h800, E_IRL = 12'h400, E_MRD = 12'h200, E_MWR = 12'h100;
   localparam logic [11:0] E_RA  = 12'h080, E_RB  = 12'h040, E_AO  = 12'h020, E_MDR = 12'h010;
   localparam logic [11:0] E_RW  = 12'h008, E_EPC = 12'h004, E_ILL = 12'h002, E_HLT = 12'h001;

   logic        clk = 1'b0;
   logic        rst_a, rst_b, sel;
   logic [31:0] instr;
   logic        alu_zero, alu_lt;
   int          errors = 0;
   int          checks = 0;

   // DUT A: MEM_LAT=3, traps enabled.  DUT B: MEM_LAT=2, traps disabled.
   logic a_pcw, a_irl, a_mrd, a_mwr, a_ra, a_rb, a_ao, a_mdr, a_rw, a_epc, a_ill, a_hlt;
   logic b_pcw, b_irl, b_mrd, b_mwr, b_ra, b_rb, b_ao, b_mdr, b_rw, b_epc, b_ill, b_hlt;
   logic [2:0] a_aluop, b_aluop;
   logic [1:0] a_sa, a_sb, a_pcs, a_wb, a_sh, b_sa, b_sb, b_pcs, b_wb, b_sh;
   logic [5:0] a_amt, b_amt;
   logic [4:0] a_st, b_st;

   control_unit_mc #(.MEM_LAT(3), .XLEN(64), .TRAP_EN(1)) u_dut_a (
      .clk(clk), .rst(rst_a), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .pc_write(a_pcw), .ir_load(a_irl), .mem_read(a_mrd), .mem_write(a_mwr),
      .rega_load(a_ra), .regb_load(a_rb), .aluout_load(a_ao), .mdr_load(a_mdr),
      .reg_write(a_rw), .epc_load(a_epc), .alu_op(a_aluop), .alu_src_a(a_sa),
      .alu_src_b(a_sb), .pc_src(a_pcs), .wb_sel(a_wb), .shift_op(a_sh),
      .shift_amt(a_amt), .illegal(a_ill), .halted(a_hlt), .state_dbg(a_st));

   control_unit_mc #(.MEM_LAT(2), .XLEN(64), .TRAP_EN(0)) u_dut_b (
      .clk(clk), .rst(rst_b), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
      .pc_write(b_pcw), .ir_load(b_irl), .mem_read(b_mrd), .mem_write(b_mwr),
      .rega_load(b_ra), .regb_load(b_rb), .aluout_load(b_ao), .mdr_load(b_mdr),
      .reg_write(b_rw), .epc_load(b_epc), .alu_op(b_aluop), .alu_src_a(b_sa),
      .alu_src_b(b_sb), .pc_src(b_pcs), .wb_sel(b_wb), .shift_op(b_sh),
      .shift_amt(b_amt), .illegal(b_ill), .halted(b_hlt), .state_dbg(b_st));

   logic [11:0] a_ctl, b_ctl, o_ctl;
   logic [20:0] a_sel, b_sel, o_sel;
   logic [4:0]  o_st;
   logic [2:0]  o_aluop;
   logic [1:0]  o_sa, o_sb, o_pcs, o_wb, o_sh;
   logic [5:0]  o_amt;

   assign a_ctl = {a_pcw, a_irl, a_mrd, a_mwr, a_ra, a_rb, a_ao, a_mdr, a_rw, a_epc, a_ill, a_hlt};
   assign b_ctl = {b_pcw, b_irl, b_mrd, b_mwr, b_ra, b_rb, b_ao, b_mdr, b_rw, b_epc, b_ill, b_hlt};
   assign a_sel = {a_aluop, a_sa, a_sb, a_pcs, a_wb, a_sh, a_amt};
   assign b_sel = {b_aluop, b_sa, b_sb, b_pcs, b_wb, b_sh, b_amt};
   assign o_ctl = sel ? b_ctl : a_ctl;
   assign o_sel = sel ? b_sel : a_sel;
   assign o_st  = sel ? b_st  : a_st;
   assign {o_aluop, o_sa, o_sb, o_pcs, o_wb, o_sh, o_amt} = o_sel;

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Load an instruction, run through FETCH and DECODE, stop in the first post-decode state.
   task automatic issue(input logic [31:0] ins);
      int n;
      instr = ins;
      n = 0;
      while (o_st !== 5'(S_DECODE) && n < 40) begin
         step();
         n++;
      end
      chk("reach_decode", 32'(n < 40), 32'd1);
      step();
   endtask

   initial begin
      sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
      instr = 32'h0000_0013; alu_zero = 1'b0; alu_lt = 1'b0;
      step(); step();
      rst_a = 1'b0;
      instr = 32'h0020_81B3;                       // add x3,x1,x2
      chk("a_reset_state", o_st, S_RESET);
      chk("a_reset_ctl",   o_ctl, 12'h000);
      chk("a_reset_sel",   o_sel, 21'h0);
      step();                                      // cycle 2: FETCH 1
      chk("fetch1_state", o_st, S_FETCH);
      chk("fetch1_ctl",   o_ctl, E_MRD);
      chk("fetch1_srcb",  o_sb, SRC_B_FOUR);
      step();
      chk("fetch2_ctl",   o_ctl, E_MRD);
      step();
      chk("fetch3_ctl",   o_ctl, E_MRD | E_IRL | E_PCW);
      chk("fetch3_pcsrc", o_pcs, PC_SRC_ALU);
      step();
      chk("decode_state", o_st, S_DECODE);
      chk("decode_ctl",   o_ctl, E_RA | E_RB | E_AO);
      chk("decode_srca",  o_sa, SRC_A_PCOLD);
      chk("decode_srcb",  o_sb, SRC_B_IMM);
      step();
      chk("execr_state", o_st, S_EXEC_R);
      chk("execr_ctl",   o_ctl, E_AO);
      chk("execr_srca",  o_sa, SRC_A_REG);
      chk("execr_aluop", o_aluop, ALU_ADD);
      step();                                      // cycle 7
      chk("wbalu_state", o_st, S_WB_ALU);
      chk("wbalu_ctl",   o_ctl, E_RW);
      chk("wbalu_wbsel", o_wb, WB_ALUOUT);

      issue(32'h4020_81B3);                        // sub x3,x1,x2
      chk("sub_aluop", o_aluop, ALU_SUB);

      issue(32'h0020_9063);                        // bne
      alu_zero = 1'b0; #1;
      chk("bne_nz_state", o_st, S_BRANCH);
      chk("bne_nz_ctl",   o_ctl, E_PCW);
      chk("bne_nz_pcsrc", o_pcs, PC_SRC_ALUOUT);
      chk("bne_aluop",    o_aluop, ALU_SUB);
      alu_zero = 1'b1; #1;
      chk("bne_z_ctl",    o_ctl, 12'h000);
      alu_zero = 1'b0;
      issue(32'h0020_C063);                        // blt
      alu_lt = 1'b1; #1;
      chk("blt_lt_ctl", o_ctl, E_PCW);
      issue(32'h0020_D063);                        // bge
      #1;
      chk("bge_lt_state", o_st, S_BRANCH);
      chk("bge_lt_ctl",   o_ctl, 12'h000);
      alu_lt = 1'b0;

      issue(32'h4033_5293);                        // srai x5,x6,3
      chk("srai_state", o_st, S_SHIFT);
      chk("srai_op",    o_sh, SH_SRA);
      chk("srai_amt",   o_amt, 6'd3);
      chk("srai_ctl",   o_ctl, E_AO);
      step();
      chk("srai_wb_state", o_st, S_WB_ALU);
      issue(32'h0010_9093);                        // slli x1,x1,1
      chk("slli_op",  o_sh, SH_SLL);
      chk("slli_amt", o_amt, 6'd1);

      issue(32'h0000_006F);                        // jal x0,0
      chk("jal_ctl",   o_ctl, E_PCW | E_RW);
      chk("jal_pcsrc", o_pcs, PC_SRC_ALUOUT);
      chk("jal_wbsel", o_wb, WB_PC);
      issue(32'h0000_8067);                        // jalr x0,0(x1)
      chk("jalr_state", o_st, S_JALR);
      chk("jalr_ctl",   o_ctl, E_PCW | E_RW);
      chk("jalr_srcb",  o_sb, SRC_B_IMM);
      chk("jalr_wbsel", o_wb, WB_PC);
      issue(32'h0000_12B7);                        // lui x5,1
      chk("lui_ctl",   o_ctl, E_RW);
      chk("lui_wbsel", o_wb, WB_IMM);

      issue(32'h4020_F1B3);                        // unsupported R-type funct
      chk("rbad_state", o_st, S_TRAP);
      issue(32'hFFFF_FFFF);
      chk("trap_state", o_st, S_TRAP);
      chk("trap_ctl",   o_ctl, E_EPC | E_PCW | E_ILL);
      chk("trap_pcsrc", o_pcs, PC_SRC_TRAP);
      step();
      chk("trap_after_state", o_st, S_FETCH);
      chk("trap_after_ctl",   o_ctl, E_MRD);

      issue(32'h0010_0073);                        // ebreak
      for (int i = 0; i < 20; i++) begin
         chk("halt_state", o_st, S_HALT);
         chk("halt_ctl",   o_ctl, E_HLT);
         step();
      end
      rst_a = 1'b1;

      sel = 1'b1;
      step();
      rst_b = 1'b0;
      chk("b_reset_state", o_st, S_RESET);
      chk("b_reset_ctl",   o_ctl, 12'h000);
      issue(32'h0000_A283);                        // lw x5,0(x1)
      chk("lw_addr_state", o_st, S_ADDR);
      chk("lw_addr_ctl",   o_ctl, E_AO);
      chk("lw_addr_srca",  o_sa, SRC_A_REG);
      chk("lw_addr_srcb",  o_sb, SRC_B_IMM);
      step();
      chk("memrd1_state", o_st, S_MEM_RD);
      chk("memrd1_ctl",   o_ctl, E_MRD);
      step();
      chk("memrd2_ctl",   o_ctl, E_MRD | E_MDR);
      step();
      chk("wbmem_state", o_st, S_WB_MEM);
      chk("wbmem_ctl",   o_ctl, E_RW);
      chk("wbmem_wbsel", o_wb, WB_MDR);
      issue(32'h0050_A023);                        // sw x5,0(x1)
      chk("sw_addr_state", o_st, S_ADDR);
      step();
      chk("memwr1_state", o_st, S_MEM_WR);
      chk("memwr1_ctl",   o_ctl, E_MWR);
      step();
      chk("memwr2_ctl",   o_ctl, E_MWR);
      step();
      chk("memwr_done_state", o_st, S_FETCH);
      chk("memwr_done_ctl",   o_ctl, E_MRD);

      issue(32'hFFFF_FFFF);                        // illegal, traps disabled
      chk("notrap_state", o_st, S_FETCH);
      chk("notrap_ctl",   o_ctl, E_MRD);

      issue(32'h0000_A283);                        // lw, reset during MEM_RD
      step();
      chk("rstmid_pre_state", o_st, S_MEM_RD);
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      chk("rstmid_state", o_st, S_RESET);
      chk("rstmid_ctl",   o_ctl, 12'h000);
      chk("rstmid_sel",   o_sel, 21'h0);
      step();
      chk("rstmid_fetch_state", o_st, S_FETCH);
      chk("rstmid_fetch_ctl",   o_ctl, E_MRD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
